// File: rtl/uart_tx_arbiter.sv
// Message-level two-port arbiter in front of uart_tx, with a one-byte holding register.
// Build options: UART_ARB_PRIORITY_EN (fixed priority to port 0), UART_ARB_TIMEOUT_EN (stall release).
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  input  logic       tx_sendable,
  output logic       tx_sendreq,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       tx_sendreq_q, tx_sendreq_d;
  logic [7:0] tx_data_q, tx_data_d;

  logic       slot_free;
  logic       req_g;
  logic       last_g;
  logic [7:0] data_g;
  logic       ack_g;
  logic       winner;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    slot_free = !tx_sendreq_q || tx_sendable;
    req_g     = grant_q ? req1  : req0;
    last_g    = grant_q ? last1 : last0;
    data_g    = grant_q ? data1 : data0;
    ack_g     = (state_q == GRANT) && req_g && slot_free;

`ifdef UART_ARB_PRIORITY_EN
    winner = !req0;
`else
    // With both requesting, alternate away from the previous grantee.
    winner = (req0 && req1) ? !grant_q : req1;
`endif

    state_d      = state_q;
    grant_d      = grant_q;
    tx_sendreq_d = tx_sendreq_q;
    tx_data_d    = tx_data_q;

    // A load on the same edge as a drain simply replaces the held byte.
    if (ack_g) begin
      tx_data_d    = data_g;
      tx_sendreq_d = 1'b1;
    end else if (tx_sendreq_q && tx_sendable) begin
      tx_sendreq_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          grant_d = winner;
        end
      end
      GRANT: begin
        if (ack_g && last_g) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    stall_cnt_d = 16'd0;
    if (state_q == GRANT && !ack_g) begin
      stall_cnt_d = stall_cnt_q;
      if (!req_g) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
        if (stall_cnt_d == TIMEOUT) begin
          state_d     = IDLE;
          stall_cnt_d = 16'd0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b1;
      tx_sendreq_q <= 1'b0;
      tx_data_q    <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      tx_sendreq_q <= tx_sendreq_d;
      tx_data_q    <= tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign ack0       = ack_g && !grant_q;
  assign ack1       = ack_g && grant_q;
  assign tx_sendreq = tx_sendreq_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q == GRANT);
  assign grant      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a message-level reference model
// checked every cycle, and hand-computed wire orders and timing points.
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       last0 = 1'b0, last1 = 1'b0;
  logic       ack0, ack1;
  logic       tx_sendable = 1'b1;
  logic       tx_sendreq;
  logic [7:0] tx_data;
  logic       busy, grant;

  localparam logic [15:0] TMO = 16'd5;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tx_sendable(tx_sendable), .tx_sendreq(tx_sendreq), .tx_data(tx_data),
    .busy(busy), .grant(grant)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0] q0[$], q1[$];          // {last, data} per byte still to offer
  logic [7:0] dut_wire[$], model_wire[$];
  bit         took0 = 0, took1 = 0, cmp_en = 0;

  // Reference model state: message ownership and a held-byte queue.
  bit         m_busy = 0;
  bit         m_grant = 1;
  logic [7:0] m_data = 8'h00;
  logic [7:0] hq[$];
  int         m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         rq, acc, lst;
    logic [7:0] d;
    if (reset) begin
      m_busy = 0; m_grant = 1; m_data = 8'h00; m_cnt = 0;
      hq.delete();
    end else begin
      rq  = m_grant ? req1 : req0;
      d   = m_grant ? data1 : data0;
      lst = m_grant ? last1 : last0;
      acc = m_busy && rq && (hq.size() == 0 || tx_sendable);
      if (hq.size() != 0 && tx_sendable) model_wire.push_back(hq.pop_front());
      if (acc) begin
        hq.push_back(d);
        m_data = d;
      end
      if (!m_busy) begin
        if (req0 || req1) begin
`ifdef UART_ARB_PRIORITY_EN
          m_grant = !req0;
`else
          if (req0 && req1) m_grant = !m_grant;
          else m_grant = req1;
`endif
          m_busy = 1;
          m_cnt  = 0;
        end
      end else if (acc && lst) begin
        m_busy = 0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (acc) m_cnt = 0;
      else if (!rq) begin
        m_cnt++;
        if (m_cnt == int'(TMO)) begin
          m_busy = 0;
          m_cnt  = 0;
        end
      end
`endif
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Requester drivers: offer the queue head, retire it once acked.
  initial forever begin
    @(posedge clock);
    #2;
    if (took0 && q0.size() > 0) void'(q0.pop_front());
    if (took1 && q1.size() > 0) void'(q1.pop_front());
    took0 = 0;
    took1 = 0;
    req0 = (q0.size() > 0);
    req1 = (q1.size() > 0);
    {last0, data0} = req0 ? q0[0] : 9'h000;
    {last1, data1} = req1 ? q1[0] : 9'h000;
  end

  // Per-cycle compare against the model, taken mid-cycle.
  initial forever begin
    bit rq, eack;
    @(negedge clock);
    took0 = ack0 && !reset;
    took1 = ack1 && !reset;
    if (!reset && tx_sendreq && tx_sendable) dut_wire.push_back(tx_data);
    if (cmp_en) begin
      rq   = m_grant ? req1 : req0;
      eack = m_busy && rq && (hq.size() == 0 || tx_sendable);
      chk("cyc_ack0", ack0, eack && !m_grant);
      chk("cyc_ack1", ack1, eack && m_grant);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_grant", grant, m_grant);
      chk("cyc_sendreq", tx_sendreq, hq.size() != 0);
      chk("cyc_data", tx_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (q0.size() == 0 && q1.size() == 0 && !req0 && !req1 && !busy && !tx_sendreq)
        done = 1;
    end
    chk("drain_bound", done, 1);
  endtask

  task automatic clear_wire();
    dut_wire.delete();
    model_wire.delete();
  endtask

  // Expected bytes packed first-to-last from the top of e.
  task automatic check_wire(input string name, input int n, input logic [39:0] e);
    logic [7:0] b;
    chk({name, "_dut_len"}, dut_wire.size(), n);
    chk({name, "_model_len"}, model_wire.size(), n);
    for (int i = 0; i < n; i++) begin
      b = e[39-8*i -: 8];
      if (i < dut_wire.size()) chk({name, "_dut_byte"}, dut_wire[i], b);
      if (i < model_wire.size()) chk({name, "_model_byte"}, model_wire[i], b);
    end
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    cmp_en = 1;
    chk("rst_sendreq", tx_sendreq, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 1);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    reset = 0;

    // Single requester, back-to-back bytes with the transmitter always ready
    clear_wire();
    q0.push_back({1'b0, 8'h55});
    q0.push_back({1'b0, 8'hAA});
    q0.push_back({1'b1, 8'h25});
    tick();
    tick();
    chk("single_t2_data", tx_data, 8'h55);
    chk("single_t2_sendreq", tx_sendreq, 1);
    chk("single_t2_busy", busy, 1);
    tick();
    chk("single_t3_data", tx_data, 8'hAA);
    tick();
    chk("single_t4_data", tx_data, 8'h25);
    chk("single_t4_busy", busy, 0);
    drain();
    check_wire("single", 3, {8'h55, 8'hAA, 8'h25, 16'h0});

    // Simultaneous contest right after reset: port 0 first
    pulse_reset();
    clear_wire();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
    q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
    drain();
    check_wire("contest1", 4, {8'h11, 8'h12, 8'h21, 8'h22, 8'h0});

    // Solo message from port 0, so port 0 is the previous grantee
    clear_wire();
    q0.push_back({1'b1, 8'h13});
    drain();
    check_wire("solo", 1, {8'h13, 32'h0});
    chk("solo_grant", grant, 0);

    // Repeat the contest
    clear_wire();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
    q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
    drain();
`ifdef UART_ARB_PRIORITY_EN
    check_wire("contest2", 4, {8'h11, 8'h12, 8'h21, 8'h22, 8'h0});
`else
    check_wire("contest2", 4, {8'h21, 8'h22, 8'h11, 8'h12, 8'h0});
`endif

    // Port 1 requests mid-message of port 0
    clear_wire();
    q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32}); q0.push_back({1'b1, 8'h33});
    tick();
    tick();
    q1.push_back({1'b0, 8'h41}); q1.push_back({1'b1, 8'h42});
    tick();
    chk("mid_ack1", ack1, 0);
    chk("mid_grant", grant, 0);
    drain();
    check_wire("mid", 5, {8'h31, 8'h32, 8'h33, 8'h41, 8'h42});

    // Transmitter stalled for 20 cycles with a byte held
    clear_wire();
    tx_sendable = 0;
    q0.push_back({1'b0, 8'h51}); q0.push_back({1'b1, 8'h52});
    repeat (20) tick();
    chk("stall_data", tx_data, 8'h51);
    chk("stall_sendreq", tx_sendreq, 1);
    chk("stall_ack0", ack0, 0);
    tx_sendable = 1;
    drain();
    check_wire("stall", 2, {8'h51, 8'h52, 24'h0});

    // Reset while a grant holds a byte
    clear_wire();
    tx_sendable = 0;
    q0.push_back({1'b0, 8'h61}); q0.push_back({1'b0, 8'h62}); q0.push_back({1'b1, 8'h63});
    repeat (5) tick();
    chk("prerst_busy", busy, 1);
    chk("prerst_sendreq", tx_sendreq, 1);
    reset = 1;
    q0.delete();
    tick();
    chk("midrst_sendreq", tx_sendreq, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", grant, 1);
    reset = 0;
    tx_sendable = 1;
    drain();
    check_wire("midrst", 0, 40'h0);

`ifdef UART_ARB_TIMEOUT_EN
    // Port 0 abandons its message; the grant is forced free and port 1 follows
    clear_wire();
    q0.push_back({1'b0, 8'h71});
    q1.push_back({1'b0, 8'h81}); q1.push_back({1'b1, 8'h82});
    drain();
    check_wire("timeout", 3, {8'h71, 8'h81, 8'h82, 16'h0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
